// File: rtl/swi_reader.sv
// -----------------------------------------------------------------------------
// swi_reader
// Reads a bus of raw mechanical switches, synchronizes and debounces every bit,
// produces per-bit rise/fall pulses and queues one change event at a time in a
// single-entry buffer with a valid/ready handshake and a sticky overflow flag.
//
// Ports
//   clk_2      in   1      single clock, all state updates on its rising edge
//   reset_n    in   1      asynchronous active-low reset
//   SWI        in   NBITS  raw switch levels (asynchronous, may bounce)
//   sw_stable  out  NBITS  debounced switch levels
//   sw_rise    out  NBITS  one-cycle pulse per bit on an accepted 0->1 change
//   sw_fall    out  NBITS  one-cycle pulse per bit on an accepted 1->0 change
//   evt_valid  out  1      change event pending
//   evt_data   out  NBITS  sw_stable snapshot of the pending event
//   evt_ready  in   1      consumer accepts the pending event
//   evt_ovf    out  1      sticky: a pending event was overwritten unaccepted
//   clr_ovf    in   1      synchronous clear of evt_ovf (a new overflow wins)
//   evt_count  out  8      wrapping count of generated change events
// -----------------------------------------------------------------------------
module swi_reader #(
  parameter int NBITS    = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic [NBITS-1:0] SWI,
  output logic [NBITS-1:0] sw_stable,
  output logic [NBITS-1:0] sw_rise,
  output logic [NBITS-1:0] sw_fall,
  output logic             evt_valid,
  output logic [NBITS-1:0] evt_data,
  input  logic             evt_ready,
  output logic             evt_ovf,
  input  logic             clr_ovf,
  output logic [7:0]       evt_count
);

  localparam int              CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  logic [NBITS-1:0] r_sync1;
  logic [NBITS-1:0] r_sync2;
  logic [CW-1:0]    r_cnt [NBITS];
  logic [NBITS-1:0] r_stable;
  logic [NBITS-1:0] r_rise;
  logic [NBITS-1:0] r_fall;
  state_t           r_state;
  logic [NBITS-1:0] r_evt_data;
  logic             r_ovf;
  logic [7:0]       r_count;

  logic [CW-1:0]    w_cnt_next [NBITS];
  logic [NBITS-1:0] w_next_stable;
  logic             w_evt;
  logic             w_ovf_set;

  // Per-bit debounce decision. A bit is only accepted on the DEBOUNCE-th
  // consecutive mismatching sample; any matching sample restarts the count.
  always_comb begin
    w_next_stable = r_stable;
    for (int i = 0; i < NBITS; i++) begin
      w_cnt_next[i] = '0;
      if (r_sync2[i] != r_stable[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_next_stable[i] = r_sync2[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // All bits changing on one edge collapse into a single event.
  assign w_evt     = |(w_next_stable ^ r_stable);
  assign w_ovf_set = (r_state == ST_FULL) && w_evt && !evt_ready;

  // Stage: two-flop synchronizer, debounce counters, stable level and pulses.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      for (int i = 0; i < NBITS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1  <= SWI;
      r_sync2  <= r_sync1;
      r_stable <= w_next_stable;
      // Pulses are aligned with the cycle sw_stable first shows the new level.
      r_rise   <= w_next_stable & ~r_stable;
      r_fall   <= ~w_next_stable & r_stable;
      for (int i = 0; i < NBITS; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  // Stage: one-entry event buffer, overflow flag and event counter.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_EMPTY;
      r_evt_data <= '0;
      r_ovf      <= 1'b0;
      r_count    <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_evt) begin
            r_evt_data <= w_next_stable;
            r_state    <= ST_FULL;
          end
        end
        ST_FULL: begin
          // A new event always replaces the entry; accepting in the same
          // cycle keeps the buffer full without counting as an overflow.
          if (w_evt) begin
            r_evt_data <= w_next_stable;
          end else if (evt_ready) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase

      // Set has priority over a simultaneous clear.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end

      if (w_evt) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign sw_stable = r_stable;
  assign sw_rise   = r_rise;
  assign sw_fall   = r_fall;
  assign evt_valid = (r_state == ST_FULL);
  assign evt_data  = r_evt_data;
  assign evt_ovf   = r_ovf;
  assign evt_count = r_count;

endmodule

// File: tb/tb_swi_reader.sv
// -----------------------------------------------------------------------------
// tb_swi_reader
// Directed bench for swi_reader (NBITS=8, DEBOUNCE=4). Inputs change 1 time
// unit after a rising edge; outputs are sampled at that same point, so a
// change applied there is first seen by the synchronizer on the next edge and
// reaches sw_stable on the 6th edge after it.
// -----------------------------------------------------------------------------
module tb_swi_reader;

  logic       clk_2 = 1'b0;
  logic       reset_n;
  logic [7:0] SWI;
  logic [7:0] sw_stable;
  logic [7:0] sw_rise;
  logic [7:0] sw_fall;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic       evt_ready;
  logic       evt_ovf;
  logic       clr_ovf;
  logic [7:0] evt_count;

  int n_checks = 0;
  int n_fail   = 0;

  swi_reader #(
    .NBITS    (8),
    .DEBOUNCE (4)
  ) u_dut (
    .clk_2     (clk_2),
    .reset_n   (reset_n),
    .SWI       (SWI),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .evt_ready (evt_ready),
    .evt_ovf   (evt_ovf),
    .clr_ovf   (clr_ovf),
    .evt_count (evt_count)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and sample 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  logic [7:0] rise_acc;
  logic       valid_acc;

  initial begin
    reset_n   = 1'b0;
    SWI       = 8'h00;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    #12;
    chk_val("rst_stable", sw_stable, 0);
    chk_val("rst_valid",  evt_valid, 0);
    chk_val("rst_data",   evt_data,  0);
    chk_val("rst_ovf",    evt_ovf,   0);
    chk_val("rst_count",  evt_count, 0);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // Latency: 0x00 -> 0x01 appears on the 6th edge, not the 5th.
    SWI = 8'h01;
    tick(5);
    chk_val("lat_early_stable", sw_stable, 8'h00);
    tick(1);
    chk_val("lat_stable", sw_stable, 8'h01);
    chk_val("lat_rise",   sw_rise,   8'h01);
    chk_val("lat_valid",  evt_valid, 1);
    chk_val("lat_data",   evt_data,  8'h01);
    chk_val("lat_count",  evt_count, 1);
    tick(1);
    chk_val("lat_rise_end", sw_rise,   8'h00);
    chk_val("lat_valid_hold", evt_valid, 1);

    // Handshake.
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk_val("hs_valid", evt_valid, 0);
    chk_val("hs_ovf",   evt_ovf,   0);

    // Glitch: bit 3 high for 3 sampled cycles only.
    rise_acc  = '0;
    valid_acc = 1'b0;
    SWI = 8'h09;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      rise_acc  |= sw_rise;
      valid_acc |= evt_valid;
    end
    SWI = 8'h01;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      rise_acc  |= sw_rise;
      valid_acc |= evt_valid;
    end
    chk_val("gl_stable", sw_stable, 8'h01);
    chk_val("gl_rise",   rise_acc,  8'h00);
    chk_val("gl_valid",  valid_acc, 0);
    chk_val("gl_count",  evt_count, 1);

    // Fall back to 0x00, then accept it.
    SWI = 8'h00;
    tick(6);
    chk_val("fall_pulse", sw_fall,   8'h01);
    chk_val("fall_data",  evt_data,  8'h00);
    chk_val("fall_count", evt_count, 2);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk_val("fall_acc_valid", evt_valid, 0);

    // Overflow: 0x01 then 0x03 with no acceptance.
    SWI = 8'h01;
    tick(8);
    chk_val("ov1_data", evt_data, 8'h01);
    chk_val("ov1_ovf",  evt_ovf,  0);
    SWI = 8'h03;
    tick(8);
    chk_val("ov2_data",  evt_data,  8'h03);
    chk_val("ov2_ovf",   evt_ovf,   1);
    chk_val("ov2_count", evt_count, 4);
    chk_val("ov2_valid", evt_valid, 1);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk_val("clr_ovf", evt_ovf, 0);

    // Clear coinciding with a new overflow: set wins.
    SWI = 8'h07;
    tick(5);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk_val("setwin_ovf",   evt_ovf,   1);
    chk_val("setwin_data",  evt_data,  8'h07);
    chk_val("setwin_count", evt_count, 5);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk_val("setwin_clr", evt_ovf, 0);

    // Accept and new event in the same cycle: stays full, no overflow.
    SWI = 8'h0F;
    tick(5);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk_val("accnew_valid", evt_valid, 1);
    chk_val("accnew_data",  evt_data,  8'h0F);
    chk_val("accnew_ovf",   evt_ovf,   0);
    chk_val("accnew_count", evt_count, 6);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk_val("accnew_drain", evt_valid, 0);

    // Simultaneous multi-bit change: 0x00 -> 0xF0 is one event.
    SWI = 8'h00;
    tick(8);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk_val("sim_pre_count", evt_count, 7);
    SWI = 8'hF0;
    tick(6);
    chk_val("sim_rise",  sw_rise,   8'hF0);
    chk_val("sim_data",  evt_data,  8'hF0);
    chk_val("sim_count", evt_count, 8);
    tick(1);
    chk_val("sim_count_once", evt_count, 8);
    chk_val("sim_rise_end",   sw_rise,   8'h00);

    // Reset mid-debounce while FULL: everything clears before the next edge.
    SWI = 8'h80;
    tick(3);
    reset_n = 1'b0;
    #1;
    chk_val("mrst_stable", sw_stable, 0);
    chk_val("mrst_rise",   sw_rise,   0);
    chk_val("mrst_fall",   sw_fall,   0);
    chk_val("mrst_valid",  evt_valid, 0);
    chk_val("mrst_data",   evt_data,  0);
    chk_val("mrst_count",  evt_count, 0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    chk_val("rel_no_pulse", sw_fall | sw_rise, 0);
    chk_val("rel_valid",    evt_valid, 0);
    tick(4);
    chk_val("rel_early", sw_stable, 8'h00);
    tick(1);
    chk_val("rel_stable", sw_stable, 8'h80);
    chk_val("rel_rise",   sw_rise,   8'h80);
    chk_val("rel_valid2", evt_valid, 1);
    chk_val("rel_count",  evt_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
